// File: rtl/answer_judge_if.sv
// Answer-judge bus: game-side inputs (state, question, decide, digits) and verdict outputs.
// The game logic drives through master; the judge consumes through slave.
interface answer_judge_if #(
    parameter int unsigned TRY_W = 4
) ();
    logic [3:0]       STATE;
    logic [23:0]      QUESTION;
    logic             DEC;
    logic [3:0]       COUNT1_IN;
    logic [3:0]       COUNT2_IN;
    logic [3:0]       COUNT3_IN;
    logic [1:0]       RESULT;
    logic             RESULT_VALID;
    logic             BUSY;
    logic [TRY_W-1:0] TRIES;

    modport master (
        output STATE, QUESTION, DEC, COUNT1_IN, COUNT2_IN, COUNT3_IN,
        input  RESULT, RESULT_VALID, BUSY, TRIES
    );

    modport slave (
        input  STATE, QUESTION, DEC, COUNT1_IN, COUNT2_IN, COUNT3_IN,
        output RESULT, RESULT_VALID, BUSY, TRIES
    );
endinterface

// File: rtl/answer_judge.sv
// Multi-cycle judge: product of three answer digits vs. a 3-digit BCD question, 8-cycle latency.
// Optional macro ANSWER_JUDGE_ORDER_EN: a correct answer must also have non-decreasing digits.
module answer_judge #(
    parameter int unsigned TRY_W = 4
) (
    input logic          CLK,
    input logic          RST,
    answer_judge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ARM, CONV0, CONV1, CONV2, MUL1, MUL2, CMP
    } state_t;

    state_t           state_q, state_d;
    logic             dec_q;
    logic             start_q;
    logic [3:0]       d1_q, d2_q, d3_q;
    logic [11:0]      q_q;
    logic             invalid_q;
    logic [9:0]       target_q;
    logic [9:0]       prod_q;
    logic [1:0]       result_q;
    logic             valid_q;
    logic [TRY_W-1:0] tries_q;
    logic [1:0]       verdict;
    logic             in_input;
    logic             in_ready;
    logic [11:0]      q_in;
    logic             unused_q;

    assign in_input = (bus.STATE == 4'b0100);
    assign in_ready = (bus.STATE == 4'b0010);
    assign q_in     = bus.QUESTION[23:12];
    assign unused_q = ^bus.QUESTION[11:0];

    function automatic logic bad_digit(input logic [3:0] d);
        return (d == 4'd0) || (d > 4'd9);
    endfunction

    // Edge detect is registered and only armed in IDLE, so edges seen while busy are dropped
    // rather than replayed when the FSM frees up.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            dec_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= bus.DEC;
            start_q <= bus.DEC && !dec_q && (state_q == IDLE) && in_input;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_q && in_input) state_d = ARM;
            ARM:     state_d = CONV0;
            CONV0:   state_d = CONV1;
            CONV1:   state_d = CONV2;
            CONV2:   state_d = MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !in_input) state_d = IDLE;
    end

    always_comb begin
        verdict = 2'b10;
        if (invalid_q) begin
            verdict = 2'b11;
        end else if (prod_q == target_q) begin
`ifdef ANSWER_JUDGE_ORDER_EN
            verdict = ((d1_q <= d2_q) && (d2_q <= d3_q)) ? 2'b01 : 2'b11;
`else
            verdict = 2'b01;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            q_q       <= '0;
            invalid_q <= 1'b0;
            target_q  <= '0;
            prod_q    <= '0;
        end else begin
            case (state_q)
                ARM: begin
                    d1_q      <= bus.COUNT1_IN;
                    d2_q      <= bus.COUNT2_IN;
                    d3_q      <= bus.COUNT3_IN;
                    q_q       <= q_in;
                    target_q  <= '0;
                    invalid_q <= bad_digit(bus.COUNT1_IN) || bad_digit(bus.COUNT2_IN) ||
                                 bad_digit(bus.COUNT3_IN) || (q_in[11:8] > 4'd9) ||
                                 (q_in[7:4] > 4'd9) || (q_in[3:0] > 4'd9) || (q_in == 12'h000);
                end
                CONV0:   target_q <= target_q * 10'd10 + {6'd0, q_q[11:8]};
                CONV1:   target_q <= target_q * 10'd10 + {6'd0, q_q[7:4]};
                CONV2:   target_q <= target_q * 10'd10 + {6'd0, q_q[3:0]};
                MUL1:    prod_q   <= {6'd0, d1_q} * {6'd0, d2_q};
                MUL2:    prod_q   <= prod_q * {6'd0, d3_q};
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            tries_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (in_ready) begin
                result_q <= '0;
                tries_q  <= '0;
            end else if (state_q == CMP && in_input) begin
                result_q <= verdict;
                valid_q  <= 1'b1;
                if (verdict == 2'b10 && tries_q != '1) tries_q <= tries_q + TRY_W'(1);
            end
        end
    end

    assign bus.RESULT       = result_q;
    assign bus.RESULT_VALID = valid_q;
    assign bus.BUSY         = (state_q != IDLE);
    assign bus.TRIES        = tries_q;
endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge: stimulus pushes model verdicts, a monitor pops on each strobe.
// Model follows ANSWER_JUDGE_ORDER_EN the same way as the design build.
module tb_answer_judge;
    localparam int unsigned TRY_W = 4;
    localparam int TRY_MAX = (1 << TRY_W) - 1;

    typedef struct {
        int result;
        int tries;
        int cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   tries_m = 0;
    int   res_m = 0;
    exp_t exp_q[$];

    answer_judge_if #(.TRY_W(TRY_W)) bus ();

    answer_judge #(.TRY_W(TRY_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && bus.RESULT_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got RESULT=%0d with no judge pending (cycle %0d)",
                         bus.RESULT, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", int'(bus.RESULT), e.result);
                chk("tries", int'(bus.TRIES), e.tries);
                chk("latency", cyc, e.cyc);
                chk("busy_at_strobe", int'(bus.BUSY), 0);
            end
        end
    end

    // Reference: verdict straight from the game rules, decimal arithmetic on the question.
    task automatic push_exp(input int a, input int b, input int c, input int q);
        exp_t e;
        int   h, t, u, qd, r;
        bit   bad;
        h   = (q >> 8) & 15;
        t   = (q >> 4) & 15;
        u   = q & 15;
        qd  = h * 100 + t * 10 + u;
        bad = (a < 1 || a > 9 || b < 1 || b > 9 || c < 1 || c > 9 ||
               h > 9 || t > 9 || u > 9 || qd == 0);
        if (bad) r = 3;
        else if (a * b * c == qd) r = 1;
        else r = 2;
`ifdef ANSWER_JUDGE_ORDER_EN
        if (r == 1 && !(a <= b && b <= c)) r = 3;
`endif
        if (r == 2 && tries_m < TRY_MAX) tries_m++;
        res_m    = r;
        e.result = r;
        e.tries  = tries_m;
        e.cyc    = cyc + 9;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int a, input int b, input int c, input int q);
        bus.COUNT1_IN = 4'(a);
        bus.COUNT2_IN = 4'(b);
        bus.COUNT3_IN = 4'(c);
        bus.QUESTION  = {12'(q), 12'h000};
    endtask

    task automatic judge(input int a, input int b, input int c, input int q);
        drive(a, b, c, q);
        bus.DEC = 1'b1;
        push_exp(a, b, c, q);
        @(negedge CLK);
        bus.DEC = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d verdicts still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic go_ready();
        bus.STATE = 4'b0010;
        @(negedge CLK);
        tries_m = 0;
        res_m   = 0;
        chk("ready_tries", int'(bus.TRIES), 0);
        chk("ready_result", int'(bus.RESULT), 0);
        bus.STATE = 4'b0100;
        @(negedge CLK);
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    initial begin
        bus.STATE = 4'b0000;
        bus.DEC   = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_result", int'(bus.RESULT), 0);
        chk("rst_valid", int'(bus.RESULT_VALID), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_tries", int'(bus.TRIES), 0);
        RST = 1'b1;
        bus.STATE = 4'b0100;
        @(negedge CLK);

        judge(4, 5, 6, 'h120);
        drain();
        for (int i = 0; i < 16; i++) begin
            judge(3, 5, 7, 'h120);
            drain();
        end
        go_ready();

        judge(0, 5, 6, 'h120);  drain();
        judge(4, 5, 6, 'h1A0);  drain();
        judge(4, 5, 6, 'h000);  drain();
        judge(4, 5, 10, 'h200); drain();
        judge(6, 5, 4, 'h120);  drain();
        judge(9, 9, 9, 'h729);  drain();
        judge(1, 1, 1, 'h001);  drain();

        // Long DEC hold, then a second accepted edge plus an edge while busy.
        drive(4, 5, 6, 'h120);
        bus.DEC = 1'b1;
        push_exp(4, 5, 6, 'h120);
        repeat (20) @(negedge CLK);
        bus.DEC = 1'b0;
        @(negedge CLK);
        judge(2, 5, 7, 'h120);
        repeat (3) @(negedge CLK);
        chk("busy_mid", int'(bus.BUSY), 1);
        bus.DEC = 1'b1;
        @(negedge CLK);
        bus.DEC = 1'b0;
        drain();
        repeat (10) @(negedge CLK);

        // Abort by leaving INPUT mid-judge.
        judge(3, 5, 7, 'h120);
        drain();
        drive(4, 5, 6, 'h120);
        bus.DEC = 1'b1;
        @(negedge CLK);
        bus.DEC = 1'b0;
        repeat (3) @(negedge CLK);
        bus.STATE = 4'b0011;
        repeat (2) @(negedge CLK);
        bus.STATE = 4'b0100;
        repeat (12) @(negedge CLK);
        chk("abort_result", int'(bus.RESULT), res_m);
        chk("abort_tries", int'(bus.TRIES), tries_m);
        chk("abort_busy", int'(bus.BUSY), 0);

        // Asynchronous reset while in MUL1.
        drive(4, 5, 6, 'h120);
        bus.DEC = 1'b1;
        @(negedge CLK);
        bus.DEC = 1'b0;
        repeat (5) @(negedge CLK);
        chk("busy_before_rst", int'(bus.BUSY), 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_result", int'(bus.RESULT), 0);
        chk("arst_busy", int'(bus.BUSY), 0);
        chk("arst_tries", int'(bus.TRIES), 0);
        chk("arst_valid", int'(bus.RESULT_VALID), 0);
        tries_m = 0;
        res_m   = 0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (15) @(negedge CLK);

        for (int n = 0; n < 40; n++) begin
            int a, b, c, q;
            if ($urandom_range(7) == 0) go_ready();
            a = int'($urandom_range(1, 9));
            b = int'($urandom_range(1, 9));
            c = int'($urandom_range(1, 9));
            if ($urandom_range(9) == 0) a = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(10, 15));
            case ($urandom_range(3))
                0, 1:    q = to_bcd(a * b * c);
                2:       q = to_bcd(int'($urandom_range(0, 999)));
                default: q = int'($urandom_range(0, 4095));
            endcase
            judge(a, b, c, q);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
